regfile_dump: RTL

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump_pkg.sv | 13 +
 rtl/regfile_dump.sv | 84 ++++++++
 2 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared core definitions for the register-file dump engine.
// State encoding and register-file geometry.
package regfile_dump_pkg;
  localparam int REG_COUNT = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } dump_state_e;
endpackage

// File: rtl/regfile_dump.sv
// Streams every register of a 32-entry register file out over a
// valid/ready port, one read per word through a spare read port.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] ra,
  input  logic [XLEN-1:0]  rd,
  output logic [XLEN-1:0]  out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] FIRST = IDX_W'(SKIP_X0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(REG_COUNT - 1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    oidx_d = oidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d = FIRST;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        data_d = rd;
        oidx_d = idx_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Index 31 ends the dump; it never wraps.
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      data_q <= '0;
      oidx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      oidx_q <= oidx_d;
    end
  end

  assign ra = idx_q;
  assign out_data = data_q;
  assign out_idx = oidx_q;
  assign out_valid = (state_q == S_SEND);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
